// File: rtl/mb_serial_crc_rx.sv
// mb_serial_crc_rx -- receive end of the serial CRC link.
// Deserialises start / DATA_W data bits (MSB first) / CRC_W CRC bits (MSB
// first) / stop, checks the CRC residue and the stop bit, and reports the
// outcome as a one-clock status pulse on the edge after the stop sample.
// Optional error counter: define MB_RX_ERRCNT_EN to build ErrCnt logic;
// otherwise ErrCnt is tied to zero.
module mb_serial_crc_rx #(
  parameter int                 DATA_W   = 8,
  parameter int                 CRC_W    = 4,
  parameter logic [CRC_W-1:0]   POLY     = 4'h3,
  parameter logic [CRC_W-1:0]   CRC_INIT = 4'h0
) (
  input  logic              CLK,
  input  logic              Reset_bar,
  input  logic              BitEn,
  input  logic              SDI,
  output logic [DATA_W-1:0] Dout,
  output logic              DValid,
  output logic              CrcErr,
  output logic              FrameErr,
  output logic              Busy,
  output logic [7:0]        ErrCnt
);

  localparam int MAX_W = (DATA_W > CRC_W) ? DATA_W : CRC_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] CRC  = 2'd2;
  localparam logic [1:0] STOP = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  bitCnt;
  logic [CRC_W-1:0]  crcReg;
  logic [DATA_W-1:0] shiftReg;
  logic              frameDone;  // stop bit was sampled on the previous edge
  logic              stopBit;    // stop-bit value captured at the stop sample
  logic              crcOk;      // residue was zero at the stop sample

  // One serial CRC step; received CRC bits go through the same update so a
  // clean frame leaves a zero residue.
  function automatic logic [CRC_W-1:0] crcNext(input logic [CRC_W-1:0] c,
                                               input logic b);
    logic fb;
    fb = c[CRC_W-1] ^ b;
    return {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  // Frame FSM, bit counter, CRC and payload shifter; all advance only on
  // BitEn strobes so gaps of any length simply hold the frame in place.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge CLK or negedge Reset_bar) begin
    if (!Reset_bar) begin
      state    <= IDLE;
      bitCnt   <= '0;
      crcReg   <= CRC_INIT;
      shiftReg <= '0;
      stopBit  <= 1'b1;
      crcOk    <= 1'b0;
    end else if (BitEn) begin
      case (state)
        IDLE: begin
          if (!SDI) begin
            bitCnt <= CNT_W'(DATA_W - 1);
            crcReg <= CRC_INIT;
            state  <= DATA;
          end
        end
        DATA: begin
          shiftReg <= {shiftReg[DATA_W-2:0], SDI};
          crcReg   <= crcNext(crcReg, SDI);
          if (bitCnt == '0) begin
            bitCnt <= CNT_W'(CRC_W - 1);
            state  <= CRC;
          end else begin
            bitCnt <= bitCnt - CNT_W'(1);
          end
        end
        CRC: begin
          crcReg <= crcNext(crcReg, SDI);
          if (bitCnt == '0) begin
            state <= STOP;
          end else begin
            bitCnt <= bitCnt - CNT_W'(1);
          end
        end
        default: begin  // STOP
          // Capture the verdict now: a back-to-back start bit on the next
          // strobe reloads the CRC register before the status pulse fires.
          stopBit <= SDI;
          crcOk   <= (crcReg == '0);
          state   <= IDLE;
        end
      endcase
    end
  end

  // Flag that the stop bit was consumed; cleared on the next edge regardless of BitEn.
  always_ff @(posedge CLK or negedge Reset_bar) begin
    if (!Reset_bar) frameDone <= 1'b0;
    else            frameDone <= BitEn && (state == STOP);
  end

  // Status pulses and payload hand-off, one edge after the stop sample.
  always_ff @(posedge CLK or negedge Reset_bar) begin
    if (!Reset_bar) begin
      Dout     <= '0;
      DValid   <= 1'b0;
      CrcErr   <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      DValid   <= 1'b0;
      CrcErr   <= 1'b0;
      FrameErr <= 1'b0;
      if (frameDone) begin
        if (!stopBit) begin
          FrameErr <= 1'b1;  // framing error masks any CRC verdict
        end else if (!crcOk) begin
          CrcErr <= 1'b1;
        end else begin
          DValid <= 1'b1;
          Dout   <= shiftReg;
        end
      end
    end
  end

  assign Busy = (state != IDLE);

`ifdef MB_RX_ERRCNT_EN
  logic errHit;
  assign errHit = frameDone && (!stopBit || !crcOk);

  // Saturating error counter, advancing on the same edge as the error pulse.
  always_ff @(posedge CLK or negedge Reset_bar) begin
    if (!Reset_bar)                        ErrCnt <= 8'h00;
    else if (errHit && (ErrCnt != 8'hFF))  ErrCnt <= ErrCnt + 8'h01;
  end
`else
  assign ErrCnt = 8'h00;
`endif

endmodule
